dq_bank_ctrl: RTL and testbench

- Sequencing controller and two-port arbiter for a bank of level-sensitive DQ latch words (WORDS x WIDTH bits, each word built from DQ latches with a shared enable).
- Two requesters (A, B) issue read or write transactions over req/ack handshakes; the block grants round-robin.
- Writes follow a fixed sequence: drive data, pulse exactly one word enable, hold data, then acknowledge.
- Reads capture the addressed latch word into a register; the block is the only driver of latch D and en.

---
 rtl/dq_bank_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dq_bank_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dq_bank_ctrl.sv
// Sequencer and round-robin two-port arbiter for a bank of DQ latch words.
// Optional write read-back check enabled by `define DQ_BANK_CTRL_VERIFY_EN.
module dq_bank_ctrl #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned WORDS     = 4,
   parameter int unsigned AW        = 2,
   parameter int unsigned PULSE_CYC = 1,
   parameter int unsigned HOLD_CYC  = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   a_req,
   input  logic                   a_we,
   input  logic [AW-1:0]          a_addr,
   input  logic [WIDTH-1:0]       a_wdata,
   output logic                   a_ack,
   output logic [WIDTH-1:0]       a_rdata,
   input  logic                   b_req,
   input  logic                   b_we,
   input  logic [AW-1:0]          b_addr,
   input  logic [WIDTH-1:0]       b_wdata,
   output logic                   b_ack,
   output logic [WIDTH-1:0]       b_rdata,
`ifdef DQ_BANK_CTRL_VERIFY_EN
   output logic                   a_err,
   output logic                   b_err,
`endif
   output logic [WIDTH-1:0]       lat_d,
   output logic [WORDS-1:0]       lat_en,
   input  logic [WORDS*WIDTH-1:0] lat_q,
   output logic                   busy
);

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StPulse,
      StHold,
      StRdcap,
`ifdef DQ_BANK_CTRL_VERIFY_EN
      StVerify,
`endif
      StAck
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             sel_b_q, we_q, last_tie_b_q;
   logic [AW-1:0]    addr_q;
   logic [WIDTH-1:0] wdata_q, a_rdata_q, b_rdata_q;
   logic             gnt, gnt_b, tie;
   logic [WIDTH-1:0] rd_word;
`ifdef DQ_BANK_CTRL_VERIFY_EN
   logic             hit, mism, a_err_q, b_err_q;
`endif

   // The pointer only moves on contended grants: a lone requester does not steal the next tie.
   assign tie   = a_req && b_req;
   assign gnt   = (state_q == StIdle) && (a_req || b_req);
   assign gnt_b = b_req && (!a_req || !last_tie_b_q);

   always_comb begin
      rd_word = '0;
`ifdef DQ_BANK_CTRL_VERIFY_EN
      hit = 1'b0;
`endif
      for (int unsigned i = 0; i < WORDS; i++) begin
         if (addr_q == AW'(i)) begin
            rd_word = lat_q[i*WIDTH +: WIDTH];
`ifdef DQ_BANK_CTRL_VERIFY_EN
            hit = 1'b1;
`endif
         end
      end
   end

`ifdef DQ_BANK_CTRL_VERIFY_EN
   assign mism = hit && (rd_word != wdata_q);
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (gnt) state_d = (gnt_b ? b_we : a_we) ? StSetup : StRdcap;
         end
         StSetup: begin
            state_d = StPulse;
            cnt_d   = 4'(PULSE_CYC - 1);
         end
         StPulse: begin
            if (cnt_q == 4'd0) begin
               state_d = StHold;
               cnt_d   = 4'(HOLD_CYC - 1);
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StHold: begin
            if (cnt_q == 4'd0) begin
`ifdef DQ_BANK_CTRL_VERIFY_EN
               state_d = StVerify;
`else
               state_d = StAck;
`endif
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
`ifdef DQ_BANK_CTRL_VERIFY_EN
         StVerify: state_d = StAck;
`endif
         StRdcap: state_d = StAck;
         StAck:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= 4'd0;
         sel_b_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         last_tie_b_q <= 1'b1;
         a_rdata_q    <= '0;
         b_rdata_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (gnt) begin
            sel_b_q <= gnt_b;
            we_q    <= gnt_b ? b_we : a_we;
            addr_q  <= gnt_b ? b_addr : a_addr;
            wdata_q <= gnt_b ? b_wdata : a_wdata;
            if (tie) last_tie_b_q <= gnt_b;
         end
         if (state_q == StRdcap) begin
            if (sel_b_q) b_rdata_q <= rd_word;
            else         a_rdata_q <= rd_word;
         end
      end
   end

`ifdef DQ_BANK_CTRL_VERIFY_EN
   // Reads clear the requester's error so err always describes its latest ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_err_q <= 1'b0;
         b_err_q <= 1'b0;
      end else if (state_q == StVerify || state_q == StRdcap) begin
         if (sel_b_q) b_err_q <= (state_q == StVerify) && mism;
         else         a_err_q <= (state_q == StVerify) && mism;
      end
   end

   assign a_err = a_err_q;
   assign b_err = b_err_q;
`endif

   always_comb begin
      lat_en = '0;
      for (int unsigned i = 0; i < WORDS; i++) begin
         lat_en[i] = (state_q == StPulse) && (addr_q == AW'(i));
      end
   end

   always_comb begin
      lat_d = '0;
      if (state_q == StSetup || state_q == StPulse || state_q == StHold
`ifdef DQ_BANK_CTRL_VERIFY_EN
          || state_q == StVerify
`endif
         ) lat_d = wdata_q;
   end

   assign busy    = (state_q != StIdle);
   assign a_ack   = (state_q == StAck) && !sel_b_q;
   assign b_ack   = (state_q == StAck) && sel_b_q;
   assign a_rdata = a_rdata_q;
   assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_dq_bank_ctrl.sv
// Directed bench for dq_bank_ctrl with a behavioural latch-bank model.
// Covers default timing and a PULSE_CYC=3/HOLD_CYC=2 instance.
module tb_dq_bank_ctrl;

`ifdef DQ_BANK_CTRL_VERIFY_EN
   localparam int VX = 1;
`else
   localparam int VX = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_req, a_we, b_req, b_we;
   logic [1:0]  a_addr, b_addr;
   logic [3:0]  a_wdata, b_wdata, a_rdata, b_rdata, lat_d, lat_en;
   logic        a_ack, b_ack, busy;
   logic [15:0] lat_q;
   logic [3:0]  mem0, mem1, mem2, mem3;
   logic        clr, stuck1;
`ifdef DQ_BANK_CTRL_VERIFY_EN
   logic        a_err, b_err, p_a_err, p_b_err;
`endif

   logic        p_a_req, p_a_we;
   logic [1:0]  p_a_addr;
   logic [3:0]  p_a_wdata, p_a_rdata, p_b_rdata, p_lat_d, p_lat_en;
   logic        p_a_ack, p_b_ack, p_busy;
   logic [15:0] p_lat_q;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Level-sensitive latch bank; word1 can be forced stuck at zero.
   always @(lat_en, lat_d, clr, stuck1) begin
      if (clr) begin
         mem0 = '0; mem1 = '0; mem2 = '0; mem3 = '0;
      end else begin
         if (lat_en[0]) mem0 = lat_d;
         if (lat_en[1]) mem1 = lat_d;
         if (lat_en[2]) mem2 = lat_d;
         if (lat_en[3]) mem3 = lat_d;
         if (stuck1) mem1 = '0;
      end
   end
   assign lat_q   = {mem3, mem2, mem1, mem0};
   assign p_lat_q = '0;

   dq_bank_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
`ifdef DQ_BANK_CTRL_VERIFY_EN
      .a_err(a_err), .b_err(b_err),
`endif
      .lat_d(lat_d), .lat_en(lat_en), .lat_q(lat_q), .busy(busy)
   );

   dq_bank_ctrl #(.PULSE_CYC(3), .HOLD_CYC(2)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .a_req(p_a_req), .a_we(p_a_we), .a_addr(p_a_addr), .a_wdata(p_a_wdata),
      .a_ack(p_a_ack), .a_rdata(p_a_rdata),
      .b_req(1'b0), .b_we(1'b0), .b_addr(2'd0), .b_wdata(4'd0),
      .b_ack(p_b_ack), .b_rdata(p_b_rdata),
`ifdef DQ_BANK_CTRL_VERIFY_EN
      .a_err(p_a_err), .b_err(p_b_err),
`endif
      .lat_d(p_lat_d), .lat_en(p_lat_en), .lat_q(p_lat_q), .busy(p_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b1; stuck1 = 1'b0;
      a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
      p_a_req = 0; p_a_we = 0; p_a_addr = 0; p_a_wdata = 0;
      #2;
      check("rst_busy", busy, 0);
      check("rst_en", lat_en, 0);
      check("rst_d", lat_d, 0);
      check("rst_acks", {a_ack, b_ack}, 0);
      check("rst_rdata", {a_rdata, b_rdata}, 0);
      #1 clr = 1'b0;
      tick();
      rst_n = 1'b1;

      // A writes word2 = 1011; inputs change after grant
      a_req = 1; a_we = 1; a_addr = 2; a_wdata = 4'b1011;
      tick();
      a_wdata = 4'b0000; a_addr = 0; a_we = 0;
      check("w1_c1_busy", busy, 1);
      check("w1_c1_en", lat_en, 0);
      check("w1_c1_d", lat_d, 4'b1011);
      tick();
      check("w1_c2_en", lat_en, 4'b0100);
      check("w1_c2_d", lat_d, 4'b1011);
      tick();
      check("w1_c3_en", lat_en, 0);
      check("w1_c3_d", lat_d, 4'b1011);
      check("w1_c3_ack", a_ack, 0);
      repeat (VX) tick();
      tick();
      check("w1_ack", {a_ack, b_ack}, 2'b10);
      check("w1_ack_d", lat_d, 0);
      check("w1_word2", lat_q[11:8], 4'b1011);
`ifdef DQ_BANK_CTRL_VERIFY_EN
      check("w1_err", a_err, 0);
`endif
      a_req = 0;
      tick();
      check("w1_idle", {busy, a_ack}, 0);

      // B reads word2
      b_req = 1; b_we = 0; b_addr = 2;
      tick();
      b_addr = 1;
      check("r1_c1", {busy, b_ack, lat_en, lat_d}, 10'b10_0000_0000);
      tick();
      check("r1_ack", {a_ack, b_ack}, 2'b01);
      check("r1_brdata", b_rdata, 4'b1011);
      check("r1_ardata", a_rdata, 0);
      b_req = 0;
      tick();
      check("r1_idle", busy, 0);

      // Tie 1: A first
      a_req = 1; a_we = 1; a_addr = 0; a_wdata = 4'b0001;
      b_req = 1; b_we = 1; b_addr = 1; b_wdata = 4'b1110;
      tick();
      check("t1_a_d", lat_d, 4'b0001);
      tick();
      check("t1_a_en", lat_en, 4'b0001);
      tick();
      repeat (VX) tick();
      tick();
      check("t1_a_ack", {a_ack, b_ack}, 2'b10);
      a_req = 0;
      tick();
      check("t1_gap", busy, 0);
      tick();
      check("t1_b_d", lat_d, 4'b1110);
      tick();
      check("t1_b_en", lat_en, 4'b0010);
      tick();
      repeat (VX) tick();
      tick();
      check("t1_b_ack", {a_ack, b_ack}, 2'b01);
      check("t1_words", lat_q[7:0], 8'b1110_0001);
      b_req = 0;
      tick();

      // Tie 2: B first
      a_req = 1; a_we = 1; a_addr = 0; a_wdata = 4'b0001;
      b_req = 1; b_we = 1; b_addr = 1; b_wdata = 4'b1110;
      tick();
      check("t2_b_d", lat_d, 4'b1110);
      tick();
      check("t2_b_en", lat_en, 4'b0010);
      tick();
      repeat (VX) tick();
      tick();
      check("t2_b_ack", {a_ack, b_ack}, 2'b01);
      b_req = 0;
      tick();
      tick();
      check("t2_a_d", lat_d, 4'b0001);
      tick();
      check("t2_a_en", lat_en, 4'b0001);
      tick();
      repeat (VX) tick();
      tick();
      check("t2_a_ack", {a_ack, b_ack}, 2'b10);
      a_req = 0;
      tick();

      // Reset during PULSE
      a_req = 1; a_we = 1; a_addr = 3; a_wdata = 4'b0110;
      tick();
      tick();
      check("rp_en_pre", lat_en, 4'b1000);
      #1 rst_n = 1'b0;
      a_req = 0;
      #1;
      check("rp_en_async", lat_en, 0);
      check("rp_busy", busy, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("rp_noack", {a_ack, b_ack, busy}, 0);
      a_req = 1; a_we = 0; a_addr = 0;
      tick();
      check("rp_rd_c1", a_ack, 0);
      tick();
      check("rp_rd_ack", a_ack, 1);
      check("rp_rd_data", a_rdata, 4'b0001);
      a_req = 0;
      tick();

      // PULSE_CYC=3, HOLD_CYC=2 instance
      p_a_req = 1; p_a_we = 1; p_a_addr = 3; p_a_wdata = 4'b0110;
      tick();
      check("p_c1", {p_lat_en, p_lat_d}, 8'b0000_0110);
      for (int i = 2; i <= 4; i++) begin
         tick();
         check("p_pulse", {p_lat_en, p_lat_d}, 8'b1000_0110);
      end
      for (int i = 5; i <= 6; i++) begin
         tick();
         check("p_hold", {p_lat_en, p_lat_d, p_a_ack}, 9'b0000_0110_0);
      end
      repeat (VX) tick();
      tick();
      check("p_ack", {p_a_ack, p_lat_d}, 5'b1_0000);
      p_a_req = 0;
      tick();
      check("p_idle", {p_busy, p_a_ack}, 0);

`ifdef DQ_BANK_CTRL_VERIFY_EN
      // Stuck word1 must report a verify error
      stuck1 = 1'b1;
      a_req = 1; a_we = 1; a_addr = 1; a_wdata = 4'b0101;
      repeat (4) tick();
      check("v_c4_ack", a_ack, 0);
      tick();
      check("v_ack", a_ack, 1);
      check("v_err", a_err, 1);
      a_req = 0;
      tick();
      check("v_err_hold", a_err, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
